bta_operand_loader: RTL

//  Upstream feeder for the 16-operand binary tree adder (BTA_RCA family).

---
 rtl/bta_pkg.sv | 23 ++
 rtl/bta_operand_bank.sv | 51 +++++
 rtl/bta_operand_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bta_pkg.sv
// Shared types and default geometry for the binary-tree-adder operand loader.
package bta_pkg;

  // Default geometry: 16 operands of 16 bits, adder settles in 4 cycles.
  localparam int DEF_N         = 16;
  localparam int DEF_M         = 16;
  localparam int DEF_ADDER_LAT = 4;

  // Derived widths for the default geometry.
  localparam int BUS_W = DEF_M * DEF_N / 4;
  localparam int SUM_W = DEF_M + $clog2(DEF_N);
  localparam int CNT_W = $clog2(DEF_N);
  localparam int LAT_W = $clog2(DEF_ADDER_LAT + 1);

  // Loader FSM states.
  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/bta_operand_bank.sv
// N x M operand register file.
// Slots are written one at a time by index, cleared together, and presented
// as four flattened buses. Slot q of each quarter sits at bits [q*M +: M].
module bta_operand_bank
  import bta_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [$clog2(N)-1:0]   wr_idx,
  input  logic [M-1:0]           wr_data,
  output logic [M*N/4-1:0]       bus_a,
  output logic [M*N/4-1:0]       bus_b,
  output logic [M*N/4-1:0]       bus_c,
  output logic [M*N/4-1:0]       bus_d
);

  localparam int QUARTER = N / 4;

  logic [M-1:0] slots [N];

  // Store one operand per write; reset and clear wipe every slot at once.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < N; i++) begin
        slots[i] <= '0;
      end
    end else if (wr_en) begin
      slots[wr_idx] <= wr_data;
    end
  end

  // Flatten the four quarters of the file onto the A/B/C/D buses.
  always_comb begin
    bus_a = '0;
    bus_b = '0;
    bus_c = '0;
    bus_d = '0;
    for (int q = 0; q < QUARTER; q++) begin
      bus_a[q*M +: M] = slots[q];
      bus_b[q*M +: M] = slots[QUARTER + q];
      bus_c[q*M +: M] = slots[2*QUARTER + q];
      bus_d[q*M +: M] = slots[3*QUARTER + q];
    end
  end

endmodule

// File: rtl/bta_operand_loader.sv
// Operand loader in front of the 16-operand binary tree adder.
// Packs a stream of operands into the A/B/C/D buses, freezes them for the
// adder latency, captures the sum/carry and offers it on a valid/ready port.
// Optional feature: define BTA_LOADER_FLUSH_EN to let in_last close a batch
// early; the unfilled slots stay zero.
module bta_operand_loader
  import bta_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int M         = DEF_M,
  parameter int ADDER_LAT = DEF_ADDER_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [M-1:0]              in_data,
  input  logic                      in_cin,
  input  logic                      in_last,
  output logic [M*N/4-1:0]          A,
  output logic [M*N/4-1:0]          B,
  output logic [M*N/4-1:0]          C,
  output logic [M*N/4-1:0]          D,
  output logic                      C0,
  input  logic [M+$clog2(N)-1:0]    sum_in,
  input  logic                      carry_in,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [M+$clog2(N)-1:0]    res_sum,
  output logic                      res_carry
);

  localparam int SUM_WIDTH = M + $clog2(N);
  localparam int CNT_WIDTH = $clog2(N);
  localparam int LAT_WIDTH = $clog2(ADDER_LAT + 1);

  state_t                 state;
  state_t                 state_next;
  logic [CNT_WIDTH-1:0]   slot_cnt;
  logic [LAT_WIDTH-1:0]   lat_cnt;
  logic                   c0_q;
  logic [SUM_WIDTH-1:0]   sum_q;
  logic                   carry_q;
  logic                   accept;
  logic                   end_flag;
  logic                   batch_end;
  logic                   capture;
  logic                   release_res;

  assign in_ready    = (state == IDLE) || (state == FILL);
  assign res_valid   = (state == HOLD);
  assign accept      = in_valid && in_ready;
  assign capture     = (state == WAIT) && (lat_cnt == '0);
  assign release_res = (state == HOLD) && res_ready;

`ifdef BTA_LOADER_FLUSH_EN
  assign end_flag = in_last;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign end_flag       = 1'b0;
`endif

  // A batch closes on the final slot, or early on in_last when flushing is built in.
  assign batch_end = accept && ((slot_cnt == CNT_WIDTH'(N - 1)) || end_flag);

  // Next-state logic for the fill / wait / hold cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = batch_end ? WAIT : FILL;
      FILL: if (batch_end) state_next = WAIT;
      WAIT: if (lat_cnt == '0) state_next = HOLD;
      HOLD: if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Slot index advances per accepted operand and parks on the closing slot until release.
  always_ff @(posedge clk) begin
    if (rst || release_res) begin
      slot_cnt <= '0;
    end else if (accept && !batch_end) begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Latency down-counter, armed by the closing handshake so capture lands ADDER_LAT edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt <= '0;
    end else if (batch_end) begin
      lat_cnt <= LAT_WIDTH'(ADDER_LAT - 1);
    end else if ((state == WAIT) && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // Carry-in travels with operand 0 and is dropped when the result is consumed.
  always_ff @(posedge clk) begin
    if (rst || release_res) begin
      c0_q <= 1'b0;
    end else if ((state == IDLE) && accept) begin
      c0_q <= in_cin;
    end
  end

  // Result register, loaded once per batch and held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (capture) begin
      sum_q   <= sum_in;
      carry_q <= carry_in;
    end
  end

  assign C0        = c0_q;
  assign res_sum   = sum_q;
  assign res_carry = carry_q;

  bta_operand_bank #(
    .N (N),
    .M (M)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .clear   (release_res),
    .wr_en   (accept),
    .wr_idx  (slot_cnt),
    .wr_data (in_data),
    .bus_a   (A),
    .bus_b   (B),
    .bus_c   (C),
    .bus_d   (D)
  );

endmodule
